// File: rtl/abro_pkg.sv
// Shared types and constants for the ABRO input front end.
//   deb_state_t      : per-channel debounce FSM state
//   DEBOUNCE_DEFAULT : default number of stable cycles needed to accept a level change
package abro_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW,
    CHECK_HIGH,
    STABLE_HIGH,
    CHECK_LOW
  } deb_state_t;

  localparam int DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/abro_debounce_channel.sv
// One input channel: a 2-flop synchroniser followed by a debounce FSM.
// The module presents the level and pulse values that the FSM is moving to
// (derived from registered state only). The parent registers them, so the
// accepted edge and the output register update land on the same clock edge.
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high
//   raw_in    : raw asynchronous input
//   level_out : debounced level the FSM is entering this cycle
//   pulse_out : high in the cycle the FSM accepts a rising edge
module abro_debounce_channel
  import abro_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic level_out,
  output logic pulse_out
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours (s1 -> s2 stays a true shift).
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= IDLE_LOW;
      cnt   <= '0;
    end else begin
      s1    <= raw_in;
      s2    <= s1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // through the case statement can leave a value unassigned (no latches).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_out = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (s2) begin
          state_nxt = CHECK_HIGH;
          cnt_nxt   = CNT_W'(1);
        end
      end
      CHECK_HIGH: begin
        if (!s2) begin
          state_nxt = IDLE_LOW;          // bounce rejected
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = '0;
          pulse_out = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (!s2) begin
          state_nxt = CHECK_LOW;
          cnt_nxt   = CNT_W'(1);
        end
      end
      CHECK_LOW: begin
        if (s2) begin
          state_nxt = STABLE_HIGH;       // glitch low: no second pulse
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Level is high while the FSM sits on the high side (or is checking a fall).
  assign level_out = (state_nxt == STABLE_HIGH) || (state_nxt == CHECK_LOW);

endmodule

// File: rtl/abro_input_conditioner.sv
// Front end for the ABRO core: synchronises and debounces A, B and R, and
// produces registered single-cycle event pulses and debounced levels.
// An R event in a given cycle suppresses any A/B event in the same cycle;
// the suppressed event is lost, not deferred.
//   clk          : system clock, rising edge
//   reset        : synchronous, active-high
//   a_raw/b_raw/r_raw       : raw asynchronous inputs
//   a_pulse/b_pulse/r_pulse : one-cycle pulses on accepted rising edges
//   a_level/b_level/r_level : debounced levels
module abro_input_conditioner
  import abro_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  input  logic r_raw,
  output logic a_pulse,
  output logic b_pulse,
  output logic r_pulse,
  output logic a_level,
  output logic b_level,
  output logic r_level
);

  logic a_lvl_nxt, b_lvl_nxt, r_lvl_nxt;
  logic a_pls_nxt, b_pls_nxt, r_pls_nxt;

  abro_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_a (
    .clk(clk), .reset(reset), .raw_in(a_raw), .level_out(a_lvl_nxt), .pulse_out(a_pls_nxt)
  );

  abro_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_b (
    .clk(clk), .reset(reset), .raw_in(b_raw), .level_out(b_lvl_nxt), .pulse_out(b_pls_nxt)
  );

  abro_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_r (
    .clk(clk), .reset(reset), .raw_in(r_raw), .level_out(r_lvl_nxt), .pulse_out(r_pls_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      a_pulse <= 1'b0;
      b_pulse <= 1'b0;
      r_pulse <= 1'b0;
      a_level <= 1'b0;
      b_level <= 1'b0;
      r_level <= 1'b0;
    end else begin
      a_pulse <= a_pls_nxt & ~r_pls_nxt;
      b_pulse <= b_pls_nxt & ~r_pls_nxt;
      r_pulse <= r_pls_nxt;
      a_level <= a_lvl_nxt;
      b_level <= b_lvl_nxt;
      r_level <= r_lvl_nxt;
    end
  end

endmodule

// File: doc/abro_input_conditioner.md
Name: abro_input_conditioner

Overview:
Upstream front end for the ABRO state machine. Takes three raw, asynchronous, bouncy inputs: A, B and the R (restart) request. It synchronises and debounces each one, then produces clean single-cycle event pulses and stable levels for the ABRO core. R has priority: an A/B event that coincides with an R event is suppressed.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised-stable cycles required to accept a level change; legal range 2..65535
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden)

Ports:
clk  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
a_raw  input  1  raw A input, asynchronous to clk
b_raw  input  1  raw B input, asynchronous to clk
r_raw  input  1  raw R (restart) input, asynchronous to clk
a_pulse  output  1  one-cycle pulse on an accepted rising edge of A
b_pulse  output  1  one-cycle pulse on an accepted rising edge of B
r_pulse  output  1  one-cycle pulse on an accepted rising edge of R
a_level  output  1  debounced level of A
b_level  output  1  debounced level of B
r_level  output  1  debounced level of R

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: all outputs 0; synchroniser flops 0; every channel FSM in IDLE_LOW; counters 0.
- Per channel: 2-flop synchroniser (s1, s2), then an FSM with a CNT_W-bit counter. All outputs are registered.
- IDLE_LOW:
  - s2=1 -> CHECK_HIGH, cnt<=1.
  - Otherwise stay.
- CHECK_HIGH:
  - s2=0 -> IDLE_LOW, cnt<=0 (bounce rejected, no pulse).
  - s2=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HIGH, level<=1, pulse<=1.
  - Otherwise cnt<=cnt+1.
- STABLE_HIGH:
  - s2=0 -> CHECK_LOW, cnt<=1.
  - Otherwise stay.
- CHECK_LOW:
  - s2=1 -> STABLE_HIGH, cnt<=0 (no second pulse).
  - s2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE_LOW, level<=0.
  - Otherwise cnt<=cnt+1.
- Falling edges never generate pulses.
- Latency: take edge 0 as the first rising edge that samples raw=1, with raw held high afterwards. The pulse is high exactly in the cycle between edge DEBOUNCE_CYCLES+1 and edge DEBOUNCE_CYCLES+2, and the level rises at the same edge. Falling-level latency is symmetric.
- Pulse width is always exactly 1 cycle. Holding a raw input high indefinitely gives one pulse only.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around. The counter is cleared whenever its state is left.
- R priority: in any cycle where the R channel's internal pulse is high, a_pulse and b_pulse are forced to 0. The A/B FSMs still advance and their levels still update, so a suppressed event is lost, not deferred. a_pulse and b_pulse may be high together when no R pulse is present.
- Reset mid-operation: any in-progress debounce is abandoned and all outputs return to 0 on the next edge. If a raw input is still high after reset deasserts, it is re-debounced from edge 0 and produces a fresh pulse.
- No combinational path from any raw input to any output.

Decomposition:
- Shared package abro_pkg holds:
  - typedef enum logic [1:0] deb_state_t {IDLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW};
  - localparam DEBOUNCE_DEFAULT = 4.
- One sub-module, abro_debounce_channel (clk, reset, raw_in, level_out, pulse_out; parameter DEBOUNCE_CYCLES), instantiated three times.
- The top level adds only the R-priority masking and the output registers.

Test Plan:
- Reset then idle, raws all 0 for 20 cycles -> all six outputs stay 0.
- DEBOUNCE_CYCLES=4: a_raw 0->1 sampled at edge 0 and held -> a_pulse high only between edges 5 and 6, a_level=1 from edge 5, no further a_pulse over 50 cycles.
- Bounce rejection: b_raw high 2 cycles, low 1, high 2, low -> b_pulse and b_level never assert. Then b_raw held high 10 cycles -> exactly one b_pulse.
- R priority: a_raw and r_raw rise on the same edge and are held -> r_pulse=1 and a_pulse=0 in that cycle; a_level=1 and r_level=1.
- Fall path: with a_level=1, drop a_raw -> a_level clears 5 edges after the first low sample, no pulse. A 1-cycle low glitch while a_level=1 -> a_level stays 1 and no new pulse.
- Reset mid-debounce: assert reset while A is in CHECK_HIGH with a_raw held high, release after 1 cycle -> outputs 0 during reset, then a_pulse fires DEBOUNCE_CYCLES+1 edges after the first post-reset edge that samples a_raw=1.
